clock_set_controller: RTL
=========================

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
- REQ-001: Parameter TIMEOUT_TICKS, default 30: number of tick_1hz pulses with no button activity after which a set mode returns to RUN.
- REQ-002: Parameter REPEAT_DLY_CYC, default 8: number of clock cycles inc_btn must be held before auto-repeat starts.
- REQ-003: Parameter REPEAT_RATE_CYC, default 4: number of clock cycles between auto-repeat pulses.
- REQ-004: clock  input  1  single system clock, rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: tick_1hz  input  1  one-cycle pulse, once per second.
- REQ-007: mode_btn  input  1  debounced, synchronized mode button (level).
- REQ-008: inc_btn  input  1  debounced, synchronized increment button (level).
- REQ-009: sec_done  input  1  seconds counter is at 59.
- REQ-010: min_done  input  1  minutes counter is at 59.
- REQ-011: sec_en  output  1  seconds counter enable pulse.
- REQ-012: min_en  output  1  minutes counter enable pulse.
- REQ-013: hour_en  output  1  hours counter enable pulse.
- REQ-014: sec_clr  output  1  seconds counter synchronous clear pulse.
- REQ-015: mode  output  2  current state: 0=RUN, 1=SET_HOUR, 2=SET_MIN.

Function
- REQ-016: All outputs shall be registered; each output pulse shall be exactly one clock wide and shall be asserted in the cycle after the input condition is sampled.
- REQ-017: A button edge shall be the button sampled 1 in the current cycle and 0 in the previous cycle, using an internal prev-register per button.
- REQ-018: FSM transitions on a mode_btn edge: RUN->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->RUN. Encoding 3 shall be unreachable and shall recover to RUN on the next cycle.
- REQ-019: In RUN, the outputs shall follow this carry chain:
  - sec_en = tick_1hz
  - min_en = tick_1hz & sec_done
  - hour_en = tick_1hz & sec_done & min_done
- REQ-020: In RUN, inc_btn shall be ignored.
- REQ-021: In SET_HOUR, each inc edge and each auto-repeat pulse shall produce a hour_en pulse. sec_en and min_en shall stay 0.
- REQ-022: In SET_MIN, each inc edge and each auto-repeat pulse shall produce a min_en pulse. hour_en shall stay 0 (no carry), and sec_en shall stay 0 (time frozen).
- REQ-023: The transition SET_MIN->RUN, whether by button or timeout, shall pulse sec_clr for one cycle together with the state change. No other transition shall assert sec_clr.
- REQ-024: Timeout counter: cleared on entry to any set state and on any button edge; incremented on tick_1hz while in a set state. On reaching TIMEOUT_TICKS, the FSM shall go to RUN with the REQ-023 behaviour if leaving SET_MIN.
- REQ-025: A simultaneous mode edge and inc edge: the mode edge shall win and the inc edge shall be discarded.
- REQ-026: A timeout coinciding with a mode edge shall produce a single transition, namely the mode-edge transition.
- REQ-027: The timeout counter width shall be ceil(log2(TIMEOUT_TICKS+1)) bits, and the counter shall saturate at TIMEOUT_TICKS rather than wrap.

Reset
- REQ-028: On reset assertion, immediately and asynchronously: mode=RUN; all pulse outputs 0; prev-registers 0; timeout and repeat counters 0.
- REQ-029: A button held high across reset release shall not generate an edge on the first cycle after release.
- REQ-030: Reset asserted mid-set or mid-repeat shall abandon the set state, and sec_clr shall not pulse.

Configuration
- REQ-031: Macro CLOCK_SET_AUTO_REPEAT_EN defined: while inc_btn is held in a set state, the first repeat pulse shall fire REPEAT_DLY_CYC cycles after the edge pulse, then one pulse every REPEAT_RATE_CYC cycles until release. Each repeat pulse shall clear the timeout counter.
- REQ-032: Macro CLOCK_SET_AUTO_REPEAT_EN undefined: there shall be no repeat logic, and only inc edges shall pulse. Parameters REPEAT_* shall be accepted but unused.

Verification
- REQ-033: Reset, then 3 tick_1hz pulses with sec_done=0 -> 3 sec_en pulses, each one cycle after its tick; min_en=0 and hour_en=0.
- REQ-034: RUN with sec_done=1, min_done=1, and a tick -> sec_en, min_en and hour_en all high in the same cycle.
- REQ-035: mode edge, then 2 inc edges -> mode=1 and 2 hour_en pulses; mode edge, then 1 inc edge -> mode=2, 1 min_en pulse, hour_en=0; mode edge -> mode=0 with a single sec_clr pulse.
- REQ-036: In SET_MIN with TIMEOUT_TICKS=30, deliver 30 ticks with no buttons -> mode=0 and sec_clr pulse one cycle after the 30th tick; with 29 ticks -> still mode=2.
- REQ-037: With the macro defined, hold inc 20 cycles in SET_HOUR -> hour_en pulses at cycles 1, 9, 13, 17 after the edge; with the macro undefined -> a single pulse.
- REQ-038: mode and inc rise in the same cycle while in SET_HOUR -> mode=2 and no hour_en or min_en. Assert reset mid-hold -> all outputs 0 immediately and mode=0.

Source files
------------

// File: rtl/clock_set_controller.sv
// clock_set_controller
//   Run/set sequencer for an HH:MM:SS clock. In RUN it turns tick_1hz into
//   the seconds/minutes/hours carry chain. Two set modes step the hours or
//   the minutes from the increment button. A set mode drops back to RUN after
//   TIMEOUT_TICKS seconds with no button activity.
//
//   Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN
//     When defined, holding inc_btn in a set mode auto-repeats. The first
//     repeat comes REPEAT_DLY_CYC cycles after the edge pulse, and later
//     repeats come every REPEAT_RATE_CYC cycles.
//     When undefined, only inc edges step the counters and REPEAT_* are unused.
//
// Ports
//   clock_i      system clock, rising edge
//   reset_i      asynchronous active-high reset
//   tick_1hz_i   one-cycle pulse once per second
//   mode_btn_i   debounced/synchronized mode button (level)
//   inc_btn_i    debounced/synchronized increment button (level)
//   sec_done_i   seconds counter at 59
//   min_done_i   minutes counter at 59
//   sec_en_o     seconds counter enable pulse
//   min_en_o     minutes counter enable pulse
//   hour_en_o    hours counter enable pulse
//   sec_clr_o    seconds counter synchronous clear pulse
//   mode_o       0=RUN, 1=SET_HOUR, 2=SET_MIN
//
// state    | meaning
// ST_RUN   | normal timekeeping, carry chain driven by tick_1hz
// ST_SET_H | inc steps hours, time frozen
// ST_SET_M | inc steps minutes, time frozen; leaving clears seconds
// ST_BAD   | unreachable encoding, recovers to ST_RUN

module clock_set_controller #(
  parameter int TIMEOUT_TICKS   = 30,
  parameter int REPEAT_DLY_CYC  = 8,
  parameter int REPEAT_RATE_CYC = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tick_1hz_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       sec_done_i,
  input  logic       min_done_i,
  output logic       sec_en_o,
  output logic       min_en_o,
  output logic       hour_en_o,
  output logic       sec_clr_o,
  output logic [1:0] mode_o
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);

  if (TIMEOUT_TICKS < 1 || REPEAT_DLY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_param
    $error("clock_set_controller: TIMEOUT_TICKS and REPEAT_* must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            mode_prev_q, inc_prev_q;
  logic            armed_q;
  logic [TW-1:0]   to_cnt_q, to_cnt_d, to_next;
  logic            sec_en_q, sec_en_d, min_en_q, min_en_d;
  logic            hour_en_q, hour_en_d, sec_clr_q, sec_clr_d;
  logic            mode_edge, inc_edge, in_set, inc_ok, inc_pulse;
  logic            rpt_fire, timeout;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ? REPEAT_DLY_CYC : REPEAT_RATE_CYC;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DLY_LD  = RW'(REPEAT_DLY_CYC - 1);
  localparam logic [RW-1:0] RPT_RATE_LD = RW'(REPEAT_RATE_CYC - 1);
  logic            rpt_act_q, rpt_act_d;
  logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
`endif

  always_comb begin
    // armed_q masks the first cycle after reset so a button held through
    // reset release is not seen as a press.
    mode_edge = armed_q & mode_btn_i & ~mode_prev_q;
    inc_edge  = armed_q & inc_btn_i & ~inc_prev_q;
    in_set    = (state_q == ST_SET_H) || (state_q == ST_SET_M);
    inc_ok    = in_set & inc_edge & ~mode_edge;   // mode press wins
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    rpt_fire  = in_set & ~mode_edge & rpt_act_q & inc_btn_i & (rpt_cnt_q == '0);
`else
    rpt_fire  = 1'b0;
`endif
    inc_pulse = inc_ok | rpt_fire;

    to_next = to_cnt_q;
    if (in_set && tick_1hz_i && (to_cnt_q != TO_MAX))
      to_next = to_cnt_q + TW'(1);
    // Timeout acts in the cycle the final tick is sampled; any press restarts it.
    timeout = in_set & ~(mode_edge | inc_edge | rpt_fire) & (to_next == TO_MAX);

    state_d   = state_q;
    sec_en_d  = 1'b0;
    min_en_d  = 1'b0;
    hour_en_d = 1'b0;
    sec_clr_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        sec_en_d  = tick_1hz_i;
        min_en_d  = tick_1hz_i & sec_done_i;
        hour_en_d = tick_1hz_i & sec_done_i & min_done_i;
        if (mode_edge) state_d = ST_SET_H;
      end
      ST_SET_H: begin
        hour_en_d = inc_pulse;
        if (mode_edge)    state_d = ST_SET_M;
        else if (timeout) state_d = ST_RUN;
      end
      ST_SET_M: begin
        min_en_d = inc_pulse;
        if (mode_edge || timeout) begin
          state_d   = ST_RUN;
          sec_clr_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!in_set || (state_d != state_q) || mode_edge || inc_edge || rpt_fire)
      to_cnt_d = '0;
    else
      to_cnt_d = to_next;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    rpt_act_d = rpt_act_q;
    rpt_cnt_d = rpt_cnt_q;
    if (inc_ok) begin
      rpt_act_d = 1'b1;
      rpt_cnt_d = RPT_DLY_LD;
    end else if (!in_set || !inc_btn_i || mode_edge || (state_d != state_q)) begin
      rpt_act_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (rpt_act_q) begin
      rpt_cnt_d = (rpt_cnt_q == '0) ? RPT_RATE_LD : rpt_cnt_q - RW'(1);
    end
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      to_cnt_q    <= '0;
      sec_en_q    <= 1'b0;
      min_en_q    <= 1'b0;
      hour_en_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      rpt_act_q   <= 1'b0;
      rpt_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_btn_i;
      inc_prev_q  <= inc_btn_i;
      armed_q     <= 1'b1;
      to_cnt_q    <= to_cnt_d;
      sec_en_q    <= sec_en_d;
      min_en_q    <= min_en_d;
      hour_en_q   <= hour_en_d;
      sec_clr_q   <= sec_clr_d;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      rpt_act_q   <= rpt_act_d;
      rpt_cnt_q   <= rpt_cnt_d;
`endif
    end
  end

  assign sec_en_o  = sec_en_q;
  assign min_en_o  = min_en_q;
  assign hour_en_o = hour_en_q;
  assign sec_clr_o = sec_clr_q;
  assign mode_o    = state_q;

endmodule
